// File: rtl/exec_dispatch_controller.sv
// Issues one instruction at a time to a bank of exec elements. Each element is started
// with a one-cycle reset pulse, and its result is returned to writeback under a timeout.
module exec_dispatch_controller #(
   parameter int NUM_UNITS = 4,
   parameter int UNIT_W    = 3,
   parameter int TAG_W     = 5,
   parameter int OP_W      = 265,
   parameter int TIMEOUT   = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    issue_valid,
   output logic                    issue_ready,
   input  logic [UNIT_W-1:0]       issue_unit,
   input  logic [TAG_W-1:0]        issue_tag,
   input  logic [OP_W-1:0]         issue_operands,
   output logic [OP_W-1:0]         op_bundle,
   output logic [NUM_UNITS-1:0]    unit_reset,
   input  logic [NUM_UNITS-1:0]    unit_completed,
   input  logic [NUM_UNITS*32-1:0] unit_out,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic [31:0]             result_data,
   output logic [TAG_W-1:0]        result_tag,
   output logic                    result_error,
   output logic                    busy
);

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESULT} state_t;

   state_t              state_q, state_d;
   logic [OP_W-1:0]     op_bundle_q, op_bundle_d;
   logic [UNIT_W-1:0]   sel_q, sel_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [31:0]         data_q, data_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                sel_completed;
   logic [31:0]         sel_out;

   // Mux by comparison so an out-of-range sel can never index past the element bank.
   always_comb begin
      sel_completed = 1'b0;
      sel_out       = '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
         if (sel_q == UNIT_W'(i)) begin
            sel_completed = unit_completed[i];
            sel_out       = unit_out[32*i +: 32];
         end
      end
   end

   always_comb begin
      unit_reset = '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
         unit_reset[i] = reset | ((state_q == LAUNCH) && (sel_q == UNIT_W'(i)));
      end
   end

   always_comb begin
      state_d     = state_q;
      op_bundle_d = op_bundle_q;
      sel_d       = sel_q;
      tag_d       = tag_q;
      data_d      = data_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (issue_valid) begin
               op_bundle_d = issue_operands;
               sel_d       = issue_unit;
               tag_d       = issue_tag;
               if (32'(issue_unit) >= NUM_UNITS) begin
                  data_d  = '0;
                  err_d   = 1'b1;
                  state_d = RESULT;
               end else begin
                  state_d = LAUNCH;
               end
            end
         end
         LAUNCH: begin
            // completed may still show the previous op here, so it is not looked at
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (sel_completed) begin
               data_d  = sel_out;
               err_d   = 1'b0;
               state_d = RESULT;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = RESULT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RESULT: begin
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         op_bundle_q <= '0;
         sel_q       <= '0;
         tag_q       <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         op_bundle_q <= op_bundle_d;
         sel_q       <= sel_d;
         tag_q       <= tag_d;
         data_q      <= data_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign issue_ready  = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign result_valid = (state_q == RESULT);
   assign op_bundle    = op_bundle_q;
   assign result_data  = data_q;
   assign result_tag   = tag_q;
   assign result_error = err_q;

endmodule

// File: doc/exec_dispatch_controller.md
Name: exec_dispatch_controller

Overview:
- Sequences one instruction at a time onto a bank of exec elements (FPU ALU, integer ALU, etc.).
- Every element uses the same contract: clk, active-high synchronous reset that doubles as "start", a sticky completed output, and a 32-bit out.
- The block accepts an issue request, latches the operand bundle, pulses the selected element's reset for one cycle, and waits for completed. It then captures out and presents the result to writeback with a valid/ready handshake, guarded by a timeout watchdog.
- Sits between the issue stage and writeback.

Parameters:
- NUM_UNITS, 4, number of exec elements attached.
- UNIT_W, 3, width of unit select; must satisfy 2^UNIT_W >= NUM_UNITS.
- TAG_W, 5, width of destination tag passed through.
- OP_W, 265, width of flattened operand bundle (pc, inst_num, const16, shift5, addr26, rs, rt, rd, fs, ft, fd).
- TIMEOUT, 255, maximum WAIT cycles before abort; 1..65535.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- issue_valid  in  1  request present.
- issue_ready  out  1  block can accept; high only in IDLE.
- issue_unit  in  UNIT_W  target element index.
- issue_tag  in  TAG_W  destination tag.
- issue_operands  in  OP_W  operand bundle.
- op_bundle  out  OP_W  latched operands, fanned out to all elements.
- unit_reset  out  NUM_UNITS  per-element reset/start.
- unit_completed  in  NUM_UNITS  per-element completed.
- unit_out  in  NUM_UNITS*32  per-element out; element i occupies bits [32i+31:32i].
- result_valid  out  1  result available.
- result_ready  in  1  writeback accepts.
- result_data  out  32  captured element output.
- result_tag  out  TAG_W  latched issue_tag.
- result_error  out  1  timeout or invalid unit.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, LAUNCH, WAIT, RESULT.
- Reset values (registered):
  - state=IDLE; op_bundle=0; result_data=0; result_tag=0; result_error=0; timeout counter=0.
  - result_valid=0, issue_ready=1, busy=0 (all three decoded from state).
- unit_reset[i] = reset OR (state==LAUNCH AND sel==i). It is combinational, so all elements are held in reset while reset is high, including reset asserted mid-operation.
- IDLE:
  - On issue_valid: latch issue_operands into op_bundle, issue_unit into sel, issue_tag into result_tag.
  - If issue_unit >= NUM_UNITS: go to RESULT with result_error=1, result_data=0; no element is touched.
  - Otherwise go to LAUNCH.
- LAUNCH: exactly one cycle; unit_reset[sel]=1; clear the counter; go to WAIT. unit_completed is ignored in LAUNCH because a stale 1 from the prior op may still be present.
- WAIT:
  - unit_completed[sel]=1: capture unit_out slice sel into result_data, set result_error=0, go to RESULT.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without completion, set result_data=0, result_error=1, go to RESULT. The element is left as-is and the next launch re-resets it.
  - Completion in the same cycle the counter hits its limit: completion wins.
- RESULT: result_valid=1 with data, tag and error stable; on result_ready go to IDLE. No new issue is accepted in RESULT.
- Latency: for an element completing one cycle after its reset deasserts, the accept edge (cycle 0) leads to result_valid=1 in cycle 3. A throughput-1 issue stream therefore sees issue_ready again in cycle 4 at the earliest, given immediate result_ready.
- unit_completed/unit_out of non-selected elements are ignored.
- op_bundle is held constant from LAUNCH through RESULT.
- Reset in any state: next state IDLE; result_valid drops in the next cycle; any in-flight result is discarded.

Test Plan:
- Basic op: unit 2's element completes one cycle after reset deasserts with out=0x3F800000; issue_unit=2, tag=7, result_ready=1 → unit_reset[2] high exactly one cycle; result_valid in cycle 3; result_data=0x3F800000, result_tag=7, error=0.
- Stale completion: unit_completed[1] already 1 when issuing to unit 1; element takes 5 cycles → result appears only after the real completion, not in LAUNCH.
- Timeout: TIMEOUT=8, unit 0 never completes → result_valid after 8 WAIT cycles, result_data=0, error=1.
- Invalid unit: NUM_UNITS=4, issue_unit=5 → no unit_reset pulse; result_valid next cycle with error=1.
- Backpressure: result_ready low for 10 cycles → data/tag stable; issue_ready=0 throughout; next op accepted the cycle after the handshake.
- Mid-op reset: assert reset in WAIT → all unit_reset high; IDLE next cycle; issue_ready=1; result_valid never asserted.
